seg_scan_mux: RTL

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

---
 rtl/seg_scan_mux_pkg.sv | 19 +
 rtl/seg_scan_mux_seg7_decode.sv | 14 +
 rtl/seg_scan_mux.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seg_scan_mux_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
// Segment vectors are ordered {g,f,e,d,c,b,a}: bit SEG_G down to bit SEG_A.
package seg_scan_mux_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  localparam int SEG_A = 0;
  localparam int SEG_G = 6;

  // Segment-on patterns for hex digits 0..F, entry [n] is digit n.
  localparam logic [15:0][SEG_G:SEG_A] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_scan_mux_seg7_decode.sv
// Combinational hex nibble to 7-segment decoder.
// Output is already in pin polarity (inverted when ACTIVE_LOW).
module seg7_decode
  import seg_scan_mux_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0]         nibble_i,
  output logic [SEG_G:SEG_A] seg_o
);

  assign seg_o = ACTIVE_LOW ? ~SEG_TABLE[nibble_i] : SEG_TABLE[nibble_i];

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scanner with per-slot blanking and frame-synchronous
// double buffering; all pins registered, one cycle behind the scan state.
module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [4*NUM_DIGITS-1:0]   digits_i,
  input  logic [NUM_DIGITS-1:0]     digit_en_i,
  input  logic [NUM_DIGITS-1:0]     dp_i,
  input  logic                      update_i,
  output logic [SEG_G:SEG_A]        cathode_o,
  output logic                      dp_out_o,
  output logic [NUM_DIGITS-1:0]     anode_o,
  output logic                      frame_done_o
);

  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DATA_W = 4 * NUM_DIGITS;

  // Every slot opens in this state; with blanking disabled the FSM lives in DRIVE.
  localparam scan_state_e SLOT_START = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;

  localparam logic [SEG_G:SEG_A]    SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic                  DP_OFF  = ACTIVE_LOW;

  logic [DIV_W-1:0]      div_q, div_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  scan_state_e           state_q, state_d;
  logic                  div_wrap, slot_wrap, frame_wrap;

  logic [DATA_W-1:0]     sh_dig_q, act_dig_q;
  logic [NUM_DIGITS-1:0] sh_en_q, act_en_q;
  logic [NUM_DIGITS-1:0] sh_dp_q, act_dp_q;

  logic [3:0]            cur_nib;
  logic                  cur_en, cur_dp, drive_on;
  logic [SEG_G:SEG_A]    seg_dec;
  logic [NUM_DIGITS-1:0] onehot;

  logic [SEG_G:SEG_A]    cathode_q, cathode_d;
  logic                  dp_out_q, dp_out_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  frame_pend_q, frame_done_q;

  always_comb begin
    div_wrap   = (div_q == DIV_W'(SCAN_DIV - 1));
    slot_wrap  = (slot_q == SLOT_W'(NUM_DIGITS - 1));
    frame_wrap = div_wrap && slot_wrap;

    div_d  = div_wrap ? '0 : div_q + 1'b1;
    slot_d = slot_q;
    if (div_wrap) begin
      slot_d = slot_wrap ? '0 : slot_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (div_d == DIV_W'(BLANK_CYCLES)) state_d = ST_DRIVE;
      ST_DRIVE: if (div_wrap) state_d = SLOT_START;
      default:  state_d = SLOT_START;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q   <= '0;
      slot_q  <= '0;
      state_q <= SLOT_START;
    end else begin
      div_q   <= div_d;
      slot_q  <= slot_d;
      state_q <= state_d;
    end
  end

  // Shadow follows every update; active only changes at the frame boundary,
  // taking the live inputs when an update lands on that very cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_dig_q  <= '0;
      sh_en_q   <= '0;
      sh_dp_q   <= '0;
      act_dig_q <= '0;
      act_en_q  <= '0;
      act_dp_q  <= '0;
    end else begin
      if (update_i) begin
        sh_dig_q <= digits_i;
        sh_en_q  <= digit_en_i;
        sh_dp_q  <= dp_i;
      end
      if (frame_wrap) begin
        act_dig_q <= update_i ? digits_i   : sh_dig_q;
        act_en_q  <= update_i ? digit_en_i : sh_en_q;
        act_dp_q  <= update_i ? dp_i       : sh_dp_q;
      end
    end
  end

  assign cur_nib = act_dig_q[{slot_q, 2'b00} +: 4];
  assign cur_en  = act_en_q[slot_q];
  assign cur_dp  = act_dp_q[slot_q];

  seg7_decode #(
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_decode (
    .nibble_i (cur_nib),
    .seg_o    (seg_dec)
  );

  // A disabled digit is fully dark: no anode, no segments, no decimal point.
  always_comb begin
    drive_on  = (state_q == ST_DRIVE) && cur_en;
    onehot    = NUM_DIGITS'(1) << slot_q;
    cathode_d = SEG_OFF;
    dp_out_d  = DP_OFF;
    anode_d   = AN_OFF;
    if (drive_on) begin
      cathode_d = seg_dec;
      dp_out_d  = cur_dp ^ ACTIVE_LOW;
      anode_d   = ACTIVE_LOW ? ~onehot : onehot;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cathode_q    <= SEG_OFF;
      dp_out_q     <= DP_OFF;
      anode_q      <= AN_OFF;
      frame_pend_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cathode_q    <= cathode_d;
      dp_out_q     <= dp_out_d;
      anode_q      <= anode_d;
      frame_pend_q <= frame_wrap;
      frame_done_q <= frame_pend_q;
    end
  end

  assign cathode_o    = cathode_q;
  assign dp_out_o     = dp_out_q;
  assign anode_o      = anode_q;
  assign frame_done_o = frame_done_q;

endmodule
